// File: rtl/ifu_fetch_buf.sv
`timescale 1ns/1ps
// ifu_fetch_buf
// Decoupled instruction-fetch unit. It issues fetch requests to instruction
// memory over a valid/ready channel and accepts in-order responses of any
// latency. It buffers up to DEPTH instructions, and hands them to decode in
// program order over a valid/ready handshake. A redirect flushes the buffer,
// discards responses still in flight, and restarts fetch at the new PC.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst_n          asynchronous reset, active-high (despite the name)
//   imem_req_*     fetch request channel (valid/ready, addr)
//   imem_rsp_*     response channel (valid, data, err); cannot be stalled
//   redirect_*     flush and restart fetch at redirect_pc
//   inst_*         instruction channel to decode (valid/ready, word, pc, err)
module ifu_fetch_buf #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter int                 DEPTH    = 4,
  parameter logic [ADDR_W-1:0]  RESET_PC = 32'h8000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  input  logic              imem_rsp_err,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

  // Instruction storage (data only, never reset)
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [ADDR_W-1:0] r_pc   [DEPTH];
  logic [DEPTH-1:0]  r_err;

  // Control state
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CW-1:0]     r_count;
  logic [CW-1:0]     r_outstanding;
  logic [CW-1:0]     r_discard;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_rsp_pc;
  logic [0:0]        r_state;

  logic              w_credit_ok;
  logic              w_req_valid;
  logic              w_req_fire;
  logic              w_inst_valid;
  logic              w_pop;
  logic              w_push;
  logic              w_misalign;
  logic [CW-1:0]     w_out_next;

  // Buffered entries plus requests in flight may never exceed DEPTH, so every
  // response that is kept always finds a free slot.
  assign w_credit_ok = ({1'b0, r_count} + {1'b0, r_outstanding}) < (CW+1)'(DEPTH);

  assign w_req_valid  = !rst_n && (r_state == ST_RUN) && !redirect_valid && w_credit_ok;
  assign w_req_fire   = w_req_valid && imem_req_ready;
  assign w_inst_valid = !rst_n && (r_count != '0) && !redirect_valid;
  assign w_pop        = w_inst_valid && inst_ready;

  // Responses are dropped while stale ones are being drained, and on a
  // redirect cycle (that response belongs to the old stream).
  assign w_push       = imem_rsp_valid && !redirect_valid && (r_discard == '0);
  assign w_misalign   = (redirect_pc[1:0] != 2'b00);

  // Requests in flight after this cycle; on a redirect this is also the number
  // of responses that must be thrown away.
  assign w_out_next   = r_outstanding + CW'(w_req_fire) - CW'(imem_rsp_valid);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_state       <= ST_RUN;
    end else if (redirect_valid) begin
      // A misaligned target leaves a single faulting entry in slot 0.
      r_rptr        <= '0;
      r_wptr        <= w_misalign ? PW'(1) : '0;
      r_count       <= w_misalign ? CW'(1) : '0;
      r_outstanding <= w_out_next;
      r_discard     <= w_out_next;
      r_fetch_pc    <= redirect_pc;
      r_rsp_pc      <= redirect_pc;
      r_state       <= w_misalign ? ST_HALT : ST_RUN;
    end else begin
      r_outstanding <= w_out_next;
      r_count       <= r_count + CW'(w_push) - CW'(w_pop);
      if (imem_rsp_valid && (r_discard != '0)) begin
        r_discard <= r_discard - CW'(1);
      end else if (w_push && imem_rsp_err) begin
        // Everything fetched past a faulting instruction is stale.
        r_discard <= w_out_next;
      end
      if (w_push && imem_rsp_err) begin
        r_state <= ST_HALT;
      end
      if (w_req_fire) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
      end
      if (w_push) begin
        r_wptr   <= r_wptr + PW'(1);
        r_rsp_pc <= r_rsp_pc + ADDR_W'(4);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (redirect_valid) begin
      if (w_misalign) begin
        r_data[0] <= '0;
        r_pc[0]   <= redirect_pc;
        r_err[0]  <= 1'b1;
      end
    end else if (w_push) begin
      r_data[r_wptr] <= imem_rsp_data;
      r_pc[r_wptr]   <= r_rsp_pc;
      r_err[r_wptr]  <= imem_rsp_err;
    end
  end

  // Outputs are forced to zero for as long as reset is held.
  assign imem_req_valid = w_req_valid;
  assign imem_req_addr  = rst_n ? '0 : r_fetch_pc;
  assign inst_valid     = w_inst_valid;
  assign inst           = rst_n ? '0 : r_data[r_rptr];
  assign inst_pc        = rst_n ? '0 : r_pc[r_rptr];
  assign inst_err       = rst_n ? 1'b0 : r_err[r_rptr];

endmodule

// File: tb/tb_ifu_fetch_buf.sv
`timescale 1ns/1ps
module tb_ifu_fetch_buf;

  localparam int          ADDR_W   = 32;
  localparam int          DATA_W   = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [DATA_W-1:0] imem_rsp_data;
  logic              imem_rsp_err;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [DATA_W-1:0] inst;
  logic [ADDR_W-1:0] inst_pc;
  logic              inst_err;

  ifu_fetch_buf #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .imem_rsp_err  (imem_rsp_err),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_err      (inst_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] infl_q[$];
  int          checks    = 0;
  int          errors    = 0;
  int          req_cnt   = 0;
  int          viol      = 0;
  bit          mem_hold  = 1'b0;
  bit          exp_auto  = 1'b0;
  logic [31:0] err_addr  = 32'hFFFF_FFFF;
  logic [31:0] exp_fetch = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_A5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input int max);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || infl_q.size() != 0) && n < max) begin
      step(1);
      n++;
    end
    chk("drain_left", 32'(exp_q.size()), 32'd0);
  endtask

  // Memory model: records accepted requests (checking their address against
  // the expected fetch PC) and answers them in order, one cycle later at the
  // earliest, unless held.
  initial begin
    logic        rsp_go;
    logic [31:0] a;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    imem_rsp_err   = 1'b0;
    forever begin
      @(negedge clk);
      rsp_go = 1'b0;
      if (!rst_n) begin
        if (imem_req_valid && imem_req_ready) begin
          chk("req_addr", imem_req_addr, exp_fetch);
          infl_q.push_back(imem_req_addr);
          req_cnt++;
          if (exp_auto) exp_q.push_back('{pc: exp_fetch, data: mem_word(exp_fetch), err: 1'b0});
          exp_fetch = exp_fetch + 32'd4;
        end
        rsp_go = !mem_hold && (infl_q.size() != 0);
      end
      @(posedge clk);
      #1;
      if (rsp_go) begin
        a = infl_q.pop_front();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(a);
        imem_rsp_err   = (a == err_addr);
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        imem_rsp_err   = 1'b0;
      end
    end
  end

  // Monitor: compares every delivered instruction with the scoreboard and
  // watches the credit/discard invariants.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        if (inst_valid && inst_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_inst: got pc %h, want none", inst_pc);
          end else begin
            e = exp_q.pop_front();
            chk("inst_pc", inst_pc, e.pc);
            chk("inst", inst, e.data);
            chk("inst_err", {31'b0, inst_err}, {31'b0, e.err});
          end
        end
        if ((32'(dut.r_count) > DEPTH) ||
            (32'(dut.r_count) + 32'(dut.r_outstanding) > DEPTH) ||
            (dut.r_discard > dut.r_outstanding))
          viol++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base;
    int          n;
    logic [31:0] b;
    rst_n          = 1'b1;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    // Reset: everything quiet even with both ready inputs high
    step(3);
    @(negedge clk);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);

    // Startup and streaming
    @(posedge clk);
    #1;
    exp_fetch = RESET_PC;
    exp_auto  = 1'b1;
    rst_n     = 1'b0;
    @(negedge clk);
    chk("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h8000_0000);
    step(3);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (inst_valid && inst_ready) n++;
    end
    chk("stream_rate", 32'(n), 32'd8);
    step(1);
    imem_req_ready = 1'b0;
    drain(50);

    // Backpressure: credits stop fetch at DEPTH
    step(1);
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    base           = req_cnt;
    step(10);
    @(negedge clk);
    chk("credit_reqs", 32'(req_cnt - base), 32'd4);
    chk("credit_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("credit_inst_valid", {31'b0, inst_valid}, 32'd1);
    step(1);
    inst_ready = 1'b1;
    step(1);
    inst_ready = 1'b0;
    step(6);
    @(negedge clk);
    chk("credit_reqs_pulse", 32'(req_cnt - base), 32'd5);
    chk("credit_req_valid2", {31'b0, imem_req_valid}, 32'd0);
    step(1);
    imem_req_ready = 1'b0;
    inst_ready     = 1'b1;
    drain(50);

    // Redirect with one buffered entry and three requests in flight
    step(1);
    exp_auto       = 1'b0;
    mem_hold       = 1'b0;
    inst_ready     = 1'b0;
    imem_req_ready = 1'b1;
    step(1);
    mem_hold = 1'b1;
    step(3);
    imem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    exp_fetch      = 32'h8000_0100;
    exp_auto       = 1'b1;
    @(negedge clk);
    chk("redir_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("redir_outstanding", 32'(infl_q.size()), 32'd3);
    step(1);
    redirect_valid = 1'b0;
    mem_hold       = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    @(negedge clk);
    chk("flush_inst_valid", {31'b0, inst_valid}, 32'd0);
    step(6);
    imem_req_ready = 1'b0;
    drain(50);

    // Misaligned redirect: one faulting entry, then halted
    step(1);
    exp_auto       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0102;
    exp_fetch      = 32'h8000_0102;
    exp_q.push_back('{pc: 32'h8000_0102, data: 32'h0, err: 1'b1});
    step(1);
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    base           = req_cnt;
    step(8);
    @(negedge clk);
    chk("misal_reqs", 32'(req_cnt - base), 32'd0);
    chk("misal_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("misal_delivered", 32'(exp_q.size()), 32'd0);
    step(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    exp_fetch      = 32'h8000_0200;
    exp_auto       = 1'b1;
    step(1);
    redirect_valid = 1'b0;
    step(6);
    imem_req_ready = 1'b0;
    drain(50);

    // Fault on the second of four responses
    step(1);
    b        = exp_fetch;
    err_addr = b + 32'd4;
    exp_auto = 1'b0;
    mem_hold = 1'b1;
    exp_q.push_back('{pc: b, data: mem_word(b), err: 1'b0});
    exp_q.push_back('{pc: b + 32'd4, data: mem_word(b + 32'd4), err: 1'b1});
    base           = req_cnt;
    imem_req_ready = 1'b1;
    inst_ready     = 1'b1;
    step(6);
    mem_hold = 1'b0;
    step(12);
    @(negedge clk);
    chk("fault_reqs", 32'(req_cnt - base), 32'd4);
    chk("fault_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("fault_delivered", 32'(exp_q.size()), 32'd0);
    chk("fault_rsp_left", 32'(infl_q.size()), 32'd0);
    step(1);
    err_addr = 32'hFFFF_FFFF;

    // Recover by redirect, fill the buffer, then reset mid-operation
    inst_ready     = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    exp_fetch      = 32'h8000_0300;
    exp_auto       = 1'b1;
    base           = req_cnt;
    step(1);
    redirect_valid = 1'b0;
    step(10);
    @(negedge clk);
    chk("fill_reqs", 32'(req_cnt - base), 32'd4);
    chk("fill_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("fill_inst_valid", {31'b0, inst_valid}, 32'd1);
    chk("fill_head_pc", inst_pc, 32'h8000_0300);
    step(1);
    imem_req_ready = 1'b0;
    rst_n          = 1'b1;
    #1;
    chk("midrst_inst_valid", {31'b0, inst_valid}, 32'd0);
    chk("midrst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    exp_q.delete();
    step(2);
    exp_auto  = 1'b0;
    exp_fetch = RESET_PC;
    rst_n     = 1'b0;
    @(negedge clk);
    chk("post_rst_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("post_rst_req_addr", imem_req_addr, RESET_PC);
    chk("post_rst_inst_valid", {31'b0, inst_valid}, 32'd0);

    chk("invariant_violations", 32'(viol), 32'd0);
    chk("exp_left", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_buf.md
Name: ifu_fetch_buf

Overview:
Decoupled instruction-fetch unit. It replaces the combinational same-cycle instruction read with a valid/ready request/response interface to instruction memory that tolerates arbitrary latency. It keeps up to DEPTH fetches in flight or buffered, hands instructions to decode in program order over a valid/ready handshake, and supports redirect (jump/branch/trap) with flush and discard of stale responses.

Parameters:
ADDR_W, 32, fetch address / PC width
DATA_W, 32, instruction word width
DEPTH, 4, buffer entries and credit limit; power of 2, >= 2
RESET_PC, 32'h8000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-high (asserted when 1)
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  ADDR_W  fetch address
imem_rsp_valid  in  1  response valid; in request order; cannot be back-pressured
imem_rsp_data  in  DATA_W  instruction word
imem_rsp_err  in  1  access fault for this response
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  ADDR_W  new fetch PC
inst_valid  out  1  instruction available to decode
inst_ready  in  1  decode accepts instruction
inst  out  DATA_W  instruction word
inst_pc  out  ADDR_W  PC of inst
inst_err  out  1  instruction carries fetch fault

Behaviour:
- Reset (async, rst_n=1):
  - buffer empty, outstanding=0, discard=0, fetch_pc=RESET_PC, state=RUN.
  - All outputs 0 while reset is asserted.
- State RUN:
  - imem_req_valid = !redirect_valid && (count + outstanding < DEPTH).
  - imem_req_addr = fetch_pc.
  - On req fire: fetch_pc += 4; outstanding += 1.
- State HALT: imem_req_valid=0; only a redirect leaves HALT.
- First request appears in the first cycle after reset deasserts.
- Response handling:
  - Each rsp_valid decrements outstanding.
  - If discard>0: drop the response and decrement discard.
  - Else push {data, pc, err} into the buffer. pc is tracked by a separate rsp_pc counter advanced by 4 per accepted response.
  - Credit accounting guarantees a push never meets a full buffer. Overflow is a design error; the bench asserts it never happens.
- rsp_err=1 on an accepted response:
  - Push the entry with err=1.
  - discard <= remaining outstanding (excluding this response).
  - state <= HALT.
- Output side:
  - inst_valid = !empty && !redirect_valid; inst/inst_pc/inst_err = head entry.
  - Pop on inst_valid && inst_ready.
  - Minimum latency rsp_valid -> inst_valid is 1 cycle (registered storage).
  - Push and pop in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
- Redirect (takes priority over all other events in that cycle):
  - Buffer flushed (count=0).
  - A response arriving in the same cycle is dropped.
  - discard <= outstanding minus that response, if present.
  - No request is issued and no pop occurs that cycle.
  - fetch_pc <= redirect_pc; rsp_pc <= redirect_pc.
  - If redirect_pc[1:0]==0: state <= RUN. The first new request goes out the following cycle (redirect->req latency 1).
  - If misaligned: buffer receives one entry {0, redirect_pc, err=1}; state <= HALT; no memory request.
- Redirect during HALT behaves identically. Redirect while discard>0 adds to discard (total = all in-flight).
- Reset mid-operation clears everything immediately. Memory responses to pre-reset requests are not permitted (system requirement).
- Invariants:
  - count + outstanding <= DEPTH.
  - discard <= outstanding.
  - Delivered inst_pc values are contiguous +4 between redirects.

Test Plan:
- Reset/startup: hold rst_n=1 -> imem_req_valid=0, inst_valid=0. Release with req_ready=1 -> request addrs 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles.
- Streaming: req_ready=1, 1-cycle response latency, inst_ready=1 -> one inst per cycle after fill. inst_pc sequential; inst equals the memory model word at each address.
- Backpressure/credits: DEPTH=4, inst_ready=0 -> exactly 4 requests, then imem_req_valid=0. One-cycle inst_ready pulse -> exactly one further request. No overflow assertion fires.
- Redirect with 3 outstanding to 0x8000_0100 -> buffer emptied, next 3 responses dropped, next delivered inst_pc=0x8000_0100.
- Misaligned redirect to 0x8000_0102 -> one inst with inst_err=1, inst_pc=0x8000_0102. No imem requests until redirect to 0x8000_0200, which then fetches normally.
- Fault: rsp_err=1 on 2nd response of 4 in flight -> insts 1 and 2 delivered (2 with inst_err=1), last 2 responses dropped, fetch stays halted until redirect.
